// File: rtl/fft_pkg.sv
// Shared constants, types, twiddle tables and index helper for the 32-point
// radix-2 DIT FFT. Build option FFT_ROUND_EN (used in fft_bfly) selects
// round-half-up product reduction instead of truncation.
package fft_pkg;

  localparam int N        = 32;
  localparam int IN_W     = 8;
  localparam int OUT_W    = 16;
  localparam int FRAC     = 10;
  localparam int TW_W     = 12;
  localparam int STAGES   = 5;
  localparam int TWI_W    = STAGES - 1;
  // Q1.7 -> Q6.10 alignment shift
  localparam int IN_SHIFT = FRAC - (IN_W - 1);

  typedef logic signed [OUT_W-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  // W32^m = cos(2*pi*m/32) - i*sin(2*pi*m/32), scaled by 1024 and rounded
  localparam logic signed [TW_W-1:0] TW_RE [0:N/2-1] = '{
    12'sd1024,  12'sd1004,  12'sd946,   12'sd851,
    12'sd724,   12'sd569,   12'sd392,   12'sd200,
    12'sd0,    -12'sd200,  -12'sd392,  -12'sd569,
   -12'sd724,  -12'sd851,  -12'sd946,  -12'sd1004
  };

  localparam logic signed [TW_W-1:0] TW_IM [0:N/2-1] = '{
    12'sd0,    -12'sd200,  -12'sd392,  -12'sd569,
   -12'sd724,  -12'sd851,  -12'sd946,  -12'sd1004,
   -12'sd1024, -12'sd1004, -12'sd946,  -12'sd851,
   -12'sd724,  -12'sd569,  -12'sd392,  -12'sd200
  };

  // Reverse the STAGES-bit index used to load the first stage
  function automatic logic [STAGES-1:0] bit_rev(input logic [STAGES-1:0] i);
    logic [STAGES-1:0] r;
    r = '0;
    for (int b = 0; b < STAGES; b++) begin
      r[b] = i[STAGES-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_radix2_if.sv
// Frame-in / spectrum-out bus of the 32-point FFT. The master drives frames
// in and observes the spectrum; the slave is the FFT core.
interface fft32_radix2_if;
  import fft_pkg::*;

  logic                   in_valid;
  logic [N*IN_W-1:0]      x_in;
  logic                   out_valid;
  logic [N*OUT_W-1:0]     out_re;
  logic [N*OUT_W-1:0]     out_im;

  modport master (
    output in_valid,
    output x_in,
    input  out_valid,
    input  out_re,
    input  out_im
  );

  modport slave (
    input  in_valid,
    input  x_in,
    output out_valid,
    output out_re,
    output out_im
  );

endinterface

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly: t = b * W32^idx, A = a + t, B = a - t.
// Build option FFT_ROUND_EN: products are reduced with round-half-up
// ((p + 512) >>> 10); otherwise they are truncated toward -inf (p >>> 10).
// Add/subtract wraps at 16 bits.
module fft_bfly
  import fft_pkg::*;
(
  input  cplx_t            i_a,
  input  cplx_t            i_b,
  input  logic [TWI_W-1:0] i_tw_idx,
  output cplx_t            o_a,
  output cplx_t            o_b
);

  localparam int PROD_W = OUT_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;

  // Full-precision signed 16b x 12b product
  function automatic logic signed [PROD_W-1:0] mul_tw(
    input sample_t                 d,
    input logic signed [TW_W-1:0]  c
  );
    return $signed({{TW_W{d[OUT_W-1]}}, d}) * $signed({{OUT_W{c[TW_W-1]}}, c});
  endfunction

  // Bring a Q8.20 sum of products back to Q6.10, keeping the low 16 bits
  function automatic sample_t reduce_prod(input logic signed [SUM_W-1:0] p);
`ifdef FFT_ROUND_EN
    return OUT_W'((p + $signed(SUM_W'(1 << (FRAC - 1)))) >>> FRAC);
`else
    return OUT_W'(p >>> FRAC);
`endif
  endfunction

  logic signed [TW_W-1:0]   w_tw_re;
  logic signed [TW_W-1:0]   w_tw_im;
  logic signed [PROD_W-1:0] w_p_rr;
  logic signed [PROD_W-1:0] w_p_ii;
  logic signed [PROD_W-1:0] w_p_ri;
  logic signed [PROD_W-1:0] w_p_ir;
  logic signed [SUM_W-1:0]  w_sum_re;
  logic signed [SUM_W-1:0]  w_sum_im;
  sample_t                  w_t_re;
  sample_t                  w_t_im;

  assign w_tw_re = TW_RE[i_tw_idx];
  assign w_tw_im = TW_IM[i_tw_idx];

  assign w_p_rr = mul_tw(i_b.re, w_tw_re);
  assign w_p_ii = mul_tw(i_b.im, w_tw_im);
  assign w_p_ri = mul_tw(i_b.re, w_tw_im);
  assign w_p_ir = mul_tw(i_b.im, w_tw_re);

  // Sums kept one bit wider than the products so nothing is lost before reduction
  assign w_sum_re = $signed({w_p_rr[PROD_W-1], w_p_rr}) - $signed({w_p_ii[PROD_W-1], w_p_ii});
  assign w_sum_im = $signed({w_p_ri[PROD_W-1], w_p_ri}) + $signed({w_p_ir[PROD_W-1], w_p_ir});

  assign w_t_re = reduce_prod(w_sum_re);
  assign w_t_im = reduce_prod(w_sum_im);

  assign o_a.re = i_a.re + w_t_re;
  assign o_a.im = i_a.im + w_t_im;
  assign o_b.re = i_a.re - w_t_re;
  assign o_b.im = i_a.im - w_t_im;

endmodule

// File: rtl/fft32_radix2.sv
// Fully parallel, fully pipelined 32-point radix-2 DIT FFT. One frame of 32
// real Q1.7 samples per clock in, 32 complex Q6.10 bins in natural order out,
// five registered butterfly stages (latency 5). No backpressure: data moves
// every cycle, in_valid only qualifies it. Build option FFT_ROUND_EN (in
// fft_bfly) selects rounding of twiddle products; latency is unchanged.
module fft32_radix2
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fft32_radix2_if.slave bus
);

  cplx_t w_x_nat   [0:N-1];
  cplx_t w_stg_in  [0:STAGES-1][0:N-1];
  cplx_t w_stg_out [0:STAGES-1][0:N-1];
  cplx_t r_stg     [0:STAGES-1][0:N-1];
  logic  r_vld_p   [0:STAGES-1];

  // Input conversion: sign-extend Q1.7 and align to Q6.10, imaginary part zero
  for (genvar n = 0; n < N; n++) begin : g_in
    assign w_x_nat[n].re = {{(OUT_W-IN_W-IN_SHIFT){bus.x_in[IN_W*n+IN_W-1]}},
                            bus.x_in[IN_W*n +: IN_W],
                            {IN_SHIFT{1'b0}}};
    assign w_x_nat[n].im = '0;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int H = 1 << s;

    // Stage 1 reads the samples in bit-reversed order so the bins leave in natural order
    if (s == 0) begin : g_src_in
      for (genvar n = 0; n < N; n++) begin : g_sel
        assign w_stg_in[s][n] = w_x_nat[bit_rev(STAGES'(n))];
      end
    end else begin : g_src_reg
      for (genvar n = 0; n < N; n++) begin : g_sel
        assign w_stg_in[s][n] = r_stg[s-1][n];
      end
    end

    // Butterfly i pairs (g*2H + j, g*2H + j + H) with twiddle W32^(j*N/(2H))
    for (genvar i = 0; i < N/2; i++) begin : g_bf
      localparam int IA = (i / H) * 2 * H + (i % H);
      localparam int IB = IA + H;
      localparam logic [TWI_W-1:0] TWI = TWI_W'((i % H) * (N / (2 * H)));

      fft_bfly u_bfly (
        .i_a      (w_stg_in[s][IA]),
        .i_b      (w_stg_in[s][IB]),
        .i_tw_idx (TWI),
        .o_a      (w_stg_out[s][IA]),
        .o_b      (w_stg_out[s][IB])
      );
    end
  end

  // Stage registers: every stage output is captured each cycle; reset flushes all frames
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int n = 0; n < N; n++) begin
          r_stg[s][n] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        for (int n = 0; n < N; n++) begin
          r_stg[s][n] <= w_stg_out[s][n];
        end
      end
    end
  end

  // Valid pipeline: in_valid travels alongside its frame through the same five stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld_p[s] <= 1'b0;
      end
    end else begin
      r_vld_p[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_vld_p[s] <= r_vld_p[s-1];
      end
    end
  end

  // Stage-5 register drives the outputs directly
  for (genvar k = 0; k < N; k++) begin : g_out
    assign bus.out_re[OUT_W*k +: OUT_W] = r_stg[STAGES-1][k].re;
    assign bus.out_im[OUT_W*k +: OUT_W] = r_stg[STAGES-1][k].im;
  end

  assign bus.out_valid = r_vld_p[STAGES-1];

endmodule

// File: tb/tb_fft32_radix2.sv
// Bench for fft32_radix2: directed frames with literal spectra, a streaming
// burst, a mid-stream reset and a randomized run, all compared every cycle
// against a behavioural fixed-point FFT model.
module tb_fft32_radix2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft32_radix2_if bus ();

  fft32_radix2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int tw_re [16];
  int tw_im [16];

  localparam int HMAX = 4096;
  logic         h_rst [HMAX];
  logic         h_vld [HMAX];
  logic [255:0] h_x   [HMAX];
  int           ecnt = 0;

  logic [255:0] frm [5];

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int w16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int red(input int p);
`ifdef FFT_ROUND_EN
    return (p + 512) >>> 10;
`else
    return p >>> 10;
`endif
  endfunction

  function automatic int rev5(input int i);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if (((i >> b) & 1) != 0) r = r | (1 << (4 - b));
    return r;
  endfunction

  function automatic int binv(input logic [511:0] v, input int k);
    logic signed [15:0] t;
    t = v[16*k +: 16];
    return int'(t);
  endfunction

  // Fixed-point FFT model: returns {im[511:0], re[511:0]}
  function automatic logic [1023:0] model(input logic [255:0] x);
    int re [32];
    int im [32];
    int h, m, a, b, tr, ti, ar, ai;
    logic signed [7:0] s8;
    logic [1023:0] r;
    for (int n = 0; n < 32; n++) begin
      s8 = x[8*rev5(n) +: 8];
      re[n] = int'(s8) * 8;
      im[n] = 0;
    end
    for (int s = 1; s <= 5; s++) begin
      h = 1 << (s - 1);
      for (int base = 0; base < 32; base += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          m = j * (32 / (2 * h));
          a = base + j;
          b = a + h;
          tr = w16(red(re[b] * tw_re[m] - im[b] * tw_im[m]));
          ti = w16(red(re[b] * tw_im[m] + im[b] * tw_re[m]));
          ar = re[a];
          ai = im[a];
          re[a] = w16(ar + tr);
          im[a] = w16(ai + ti);
          re[b] = w16(ar - tr);
          im[b] = w16(ai - ti);
        end
      end
    end
    for (int k = 0; k < 32; k++) begin
      r[16*k +: 16]       = re[k][15:0];
      r[512 + 16*k +: 16] = im[k][15:0];
    end
    return r;
  endfunction

  task automatic lit(input string nm, input int k, input int act, input int req, input int tol);
    checks++;
    if (act - req > tol || req - act > tol) begin
      failures++;
      $display("FAIL %s bin%0d actual=%0d required=%0d", nm, k, act, req);
    end
  endtask

  task automatic cmp_frame(input string nm, input logic [1023:0] act, input logic [1023:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      for (int k = 0; k < 64; k++) begin
        if (act[16*k +: 16] !== req[16*k +: 16]) begin
          $display("FAIL %s t=%0t %s bin%0d actual=%h required=%h", nm, $time,
                   (k < 32) ? "re" : "im", k % 32, act[16*k +: 16], req[16*k +: 16]);
          break;
        end
      end
    end
  endtask

  task automatic lit_bit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // Hand-derived spectra of the directed frames
  task automatic check_frame(input string who, input int idx, input logic [1023:0] v);
    logic [511:0] vr, vi;
    vr = v[511:0];
    vi = v[1023:512];
    case (idx)
      0: for (int k = 0; k < 32; k++) begin
           lit({who, "_pulse_re"}, k, binv(vr, k), 512, 0);
           lit({who, "_pulse_im"}, k, binv(vi, k), 0, 0);
         end
      1: for (int k = 0; k < 32; k++) begin
           lit({who, "_dc_re"}, k, binv(vr, k), (k == 0) ? 16384 : 0, 0);
           lit({who, "_dc_im"}, k, binv(vi, k), 0, 0);
         end
      2: for (int k = 0; k < 32; k++) begin
           lit({who, "_alt_re"}, k, binv(vr, k), (k == 16) ? 16384 : 0, 0);
           lit({who, "_alt_im"}, k, binv(vi, k), 0, 0);
         end
      3: begin
           lit({who, "_dpulse_re"}, 0,  binv(vr, 0),  512, 0);
           lit({who, "_dpulse_im"}, 0,  binv(vi, 0),  0, 0);
           lit({who, "_dpulse_re"}, 8,  binv(vr, 8),  0, 0);
           lit({who, "_dpulse_im"}, 8,  binv(vi, 8),  -512, 0);
           lit({who, "_dpulse_re"}, 16, binv(vr, 16), -512, 0);
           lit({who, "_dpulse_im"}, 16, binv(vi, 16), 0, 0);
           lit({who, "_dpulse_re"}, 4,  binv(vr, 4),  362, 1);
           lit({who, "_dpulse_im"}, 4,  binv(vi, 4),  -362, 1);
         end
      default: ;
    endcase
  endtask

  // Record what the DUT samples at each rising edge
  always @(posedge clk) begin
    if (ecnt < HMAX) begin
      h_rst[ecnt] = rst;
      h_vld[ecnt] = bus.in_valid;
      h_x[ecnt]   = bus.x_in;
    end
    ecnt = ecnt + 1;
  end

  // Output after edge e is the FFT of the frame sampled at edge e-4,
  // unless a reset was sampled at any of edges e-4..e
  always @(negedge clk) begin
    int e;
    logic zero;
    logic exp_v;
    if (ecnt > 0 && ecnt <= HMAX) begin
      e = ecnt - 1;
      zero = 1'b0;
      for (int d = 0; d <= 4; d++) begin
        if (e - d < 0) zero = 1'b1;
        else if (h_rst[e-d] === 1'b1) zero = 1'b1;
      end
      exp_v = zero ? 1'b0 : h_vld[e-4];
      lit_bit("out_valid", bus.out_valid, exp_v);
      if (zero) cmp_frame("flushed", {bus.out_im, bus.out_re}, '0);
      else if (exp_v) cmp_frame("spectrum", {bus.out_im, bus.out_re}, model(h_x[e-4]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] x;
    for (int m = 0; m < 16; m++) begin
      tw_re[m] = rnd(1024.0 * $cos(2.0 * 3.14159265358979 * m / 32.0));
      tw_im[m] = rnd(-1024.0 * $sin(2.0 * 3.14159265358979 * m / 32.0));
    end

    // Directed frames: pulse, DC, alternating, delayed pulse, random
    frm[0] = '0;
    frm[0][7:0] = 8'h40;
    for (int n = 0; n < 32; n++) begin
      frm[1][8*n +: 8] = 8'h40;
      frm[2][8*n +: 8] = (n % 2 == 0) ? 8'h40 : 8'hC0;
    end
    frm[3] = '0;
    frm[3][15:8] = 8'h40;
    for (int w = 0; w < 8; w++) frm[4][32*w +: 32] = $urandom;

    for (int i = 0; i < 4; i++) check_frame("model", i, model(frm[i]));

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    repeat (3) @(negedge clk);
    lit_bit("reset_out_valid", bus.out_valid, 1'b0);
    cmp_frame("reset_data", {bus.out_im, bus.out_re}, '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back burst; frame 0 appears at the 5th negedge after it was driven
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) lit_bit("latency_idle", bus.out_valid, 1'b0);
      if (c >= 5) begin
        lit_bit("latency_valid", bus.out_valid, 1'b1);
        check_frame("dut", c - 5, {bus.out_im, bus.out_re});
      end
      if (c < 5) begin
        bus.in_valid = 1'b1;
        bus.x_in = frm[c];
      end else begin
        bus.in_valid = 1'b0;
        bus.x_in = '0;
      end
    end
    repeat (4) @(negedge clk);

    // Mid-stream reset with three frames in flight
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom;
      bus.in_valid = 1'b1;
      bus.x_in = x;
      @(negedge clk);
    end
    rst = 1'b1;
    bus.x_in = frm[1];
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    lit_bit("midrst_out_valid", bus.out_valid, 1'b0);
    cmp_frame("midrst_data", {bus.out_im, bus.out_re}, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lit_bit("midrst_no_stale", bus.out_valid, 1'b0);
    end

    // Randomized traffic with occasional resets
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom;
      if ($urandom_range(0, 9) == 0) x = {32{8'h80}};
      if ($urandom_range(0, 9) == 0) x = {32{8'h7F}};
      bus.x_in = x;
      @(negedge clk);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
